// File: rtl/mips_control_muldiv_sequencer.sv
// mips_control_muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO pair.
// One operand bit is processed per RUN cycle (shift-add multiply or restoring
// divide); signs are stripped in PREP and reapplied in FIX.
// Optional feature: define MIPS_CONTROL_MULDIV_EARLY_OUT_EN to let multiplies
// leave RUN as soon as the remaining multiplier bits are all zero.
module mips_control_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             readHi,
    input  logic             readLo,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             ready,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state;
    logic               is_signed;
    logic               is_div;
    logic               neg_prod;
    logic               neg_rem;
    logic [WIDTH-1:0]   rs_orig;   // original rs, kept for divide-by-zero HI
    logic [WIDTH-1:0]   op_a;      // raw rt after issue, then mplier or dividend
    logic [2*WIDTH-1:0] op_b;      // mcand (shifts left) or divisor (low half)
    logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic               mul_early;
    logic               run_last;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign ready = (state == IDLE);
    assign busy  = ~ready;
    assign stall = busy & (start | readHi | readLo | writeHi | writeLo);

    // Operand magnitudes and the single-iteration datapath for both operations.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        mag_rs       = rs_orig;
        mag_rt       = op_a;
        mul_early    = 1'b0;
        if (is_signed && rs_orig[WIDTH-1]) mag_rs = -rs_orig;
        if (is_signed && op_a[WIDTH-1])    mag_rt = -op_a;

        mul_acc_next = acc + (op_a[0] ? op_b : '0);

        div_trial    = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
        div_ge       = (div_trial >= {1'b0, op_b[WIDTH-1:0]});
        div_rem_next = div_ge ? (div_trial[WIDTH-1:0] - op_b[WIDTH-1:0])
                              : div_trial[WIDTH-1:0];

`ifdef MIPS_CONTROL_MULDIV_EARLY_OUT_EN
        // This iteration consumes the last set multiplier bit (or none is left).
        mul_early = ~is_div && (op_a[WIDTH-1:1] == '0);
`else
        mul_early = 1'b0;
`endif
        run_last = (count == LAST) || mul_early;
    end

    // Sign fix-up and special cases applied when the loop has finished.
    always_comb begin
        prod   = neg_prod ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (op_b[WIDTH-1:0] == '0) begin
                fix_hi = rs_orig;
                fix_lo = '1;
            end else begin
                fix_lo = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Sequencer FSM with the HI/LO registers and the registered done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
            state     <= IDLE;
            is_signed <= 1'b0;
            is_div    <= 1'b0;
            neg_prod  <= 1'b0;
            neg_rem   <= 1'b0;
            rs_orig   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_signed <= ~op[0];
                        is_div    <= op[1];
                        rs_orig   <= rs;
                        op_a      <= rt;
                        state     <= PREP;
                    end else begin
                        if (writeHi) hi <= writeData;
                        if (writeLo) lo <= writeData;
                    end
                end
                PREP: begin
                    neg_prod <= is_signed & (rs_orig[WIDTH-1] ^ op_a[WIDTH-1]);
                    neg_rem  <= is_signed & rs_orig[WIDTH-1];
                    acc      <= '0;
                    count    <= '0;
                    if (is_div) begin
                        op_a <= mag_rs;
                        op_b <= {{WIDTH{1'b0}}, mag_rt};
                    end else begin
                        op_a <= mag_rt;
                        op_b <= {{WIDTH{1'b0}}, mag_rs};
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (is_div) begin
                        acc  <= {div_rem_next, acc[WIDTH-2:0], div_ge};
                        op_a <= op_a << 1;
                    end else begin
                        acc  <= mul_acc_next;
                        op_b <= op_b << 1;
                        op_a <= op_a >> 1;
                    end
                    count <= count + CW'(1);
                    if (run_last) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_muldiv_sequencer.sv
// Self-checking bench for mips_control_muldiv_sequencer (WIDTH = 32, default build).
// A transaction-level model (plain 64-bit arithmetic plus a busy countdown)
// is checked against the DUT every cycle; directed vectors carry literal
// expectations that also pin the model.
module tb_mips_control_muldiv_sequencer;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;   // edges from acceptance to HI/LO update

    logic          clock;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs, rt;
    logic          readHi, readLo, writeHi, writeLo;
    logic [W-1:0]  writeData;
    logic          ready, busy, stall, done;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int            m_left = 0;
    logic [W-1:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic          m_done = 1'b0;

    mips_control_muldiv_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .readHi(readHi), .readLo(readLo), .writeHi(writeHi), .writeLo(writeLo),
        .writeData(writeData), .ready(ready), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q, r;
        logic [63:0]     res;
        case (o)
            2'd0: res = 64'(sa * sb);
            2'd1: res = ua * ub;
            default: begin
                if (b == '0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    q   = longint'(ua / ub);
                    r   = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Model: idle/busy countdown, HI/LO updates and the done pulse.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    {p_hi, p_lo} = model_result(op, rs, rt);
                    m_left = LATENCY;
                end else begin
                    if (writeHi) m_hi = writeData;
                    if (writeLo) m_lo = writeData;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        logic e_busy;
        e_busy = (m_left != 0);
        check("cyc_ready", 64'(ready), 64'(!e_busy));
        check("cyc_busy",  64'(busy),  64'(e_busy));
        check("cyc_stall", 64'(stall), 64'(e_busy & (start | readHi | readLo | writeHi | writeLo)));
        check("cyc_done",  64'(done),  64'(m_done));
        check("cyc_hi",    64'(hi),    64'(m_hi));
        check("cyc_lo",    64'(lo),    64'(m_lo));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; rs = a; rt = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; returns edges taken and busy cycles with stall high.
    task automatic wait_done(output int n, output int stall_n);
        n = 0; stall_n = 0;
        while (n < 100) begin
            stall_n += int'(stall);
            tick();
            n++;
            if (done) break;
        end
        check("done_wait", 64'(done), 64'(1));
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n, s;
        check({name, "_model"}, model_result(o, a, b), {eh, el});
        start_op(o, a, b);
        wait_done(n, s);
        check({name, "_latency"}, 64'(n), 64'(LATENCY));
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
        check({name, "_ready"}, 64'(ready), 64'(1));
    endtask

    initial begin
        int n, s;
        logic seen;
        reset = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0;
        readHi = 1'b0; readLo = 1'b0; writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
        repeat (3) tick();
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_done",  64'(done),  64'(0));
        check("rst_hi",    64'(hi),    64'(0));
        check("rst_lo",    64'(lo),    64'(0));
        reset = 1'b0;
        tick();

        // MTLO in idle takes effect at the next edge
        writeLo = 1'b1; writeData = 32'h1234_5678;
        tick();
        writeLo = 1'b0;
        check("mtlo_idle", 64'(lo), 64'h1234_5678);

        // start wins over a simultaneous MTHI; the write is discarded
        writeHi = 1'b1; writeData = 32'hDEAD_BEEF;
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        writeHi = 1'b0;

        // back-to-back directed vectors (each start lands in the previous done cycle)
        run_op("div_m7_2",   2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("mult_m3_5",  2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu_by0",   2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_intmin", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2",   2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_m100_m7",2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E);
        run_op("div_m5_by0", 2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("mult_max",   2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("divu_max_3", 2'd3, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555);
        run_op("mult_min",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("multu_2_16", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        tick();

        // MFLO held through an operation: stall every busy cycle, low in the done cycle
        readLo = 1'b1;
        start_op(2'd1, 32'd6, 32'd7);
        wait_done(n, s);
        check("mflo_stall_cycles", 64'(s), 64'(LATENCY));
        check("mflo_stall_done",   64'(stall), 64'(0));
        readLo = 1'b0;
        tick();

        // MTHI while busy is ignored; the same MTHI in idle lands at the next edge
        start_op(2'd1, 32'd6, 32'd7);
        writeHi = 1'b1; writeData = 32'hA5A5_A5A5;
        repeat (3) tick();
        writeHi = 1'b0;
        wait_done(n, s);
        check("mthi_busy_hi", 64'(hi), 64'h0);
        check("mthi_busy_lo", 64'(lo), 64'd42);
        writeHi = 1'b1;
        tick();
        writeHi = 1'b0;
        check("mthi_idle_hi", 64'(hi), 64'hA5A5_A5A5);

        // reset in the middle of RUN discards the in-flight result
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) tick();
        check("mid_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hi",    64'(hi),    64'(0));
        check("abort_lo",    64'(lo),    64'(0));
        check("abort_ready", 64'(ready), 64'(1));
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= done;
        end
        check("abort_no_done", 64'(seen), 64'(0));
        run_op("multu_2_3", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
